// File: rtl/fdma_pkg.sv
// fdma_pkg: shared definitions for the FDMA port arbiter.
//   sched_state_e : per-direction scheduler state (IDLE/ISSUE/RUN/DONE)
//   STATS_CNT_W   : width of the per-channel completion counters that
//                   exist when FDMA_ARB_STATS_EN is defined
package fdma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int unsigned STATS_CNT_W = 16;

endpackage

// File: rtl/fdma_chan_sched.sv
// fdma_chan_sched: round-robin scheduler for one FDMA direction.
// Picks a pending requester, latches its address/size, issues one FDMA
// request, waits for the FDMA engine to finish and pulses done.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ch_areq/addr/size    per-channel request level, start address, beats
//   ch_busy, ch_done     per-channel accepted flag and completion pulse
//   fdma_areq/addr/size  request towards the FDMA engine
//   fdma_busy            FDMA engine transfer in progress
//   run, grant           data-routing enable and granted channel index
module fdma_chan_sched
  import fdma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_areq,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*32-1:0]     ch_size,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     fdma_areq,
  output logic [ADDR_W-1:0]        fdma_addr,
  output logic [31:0]              fdma_size,
  input  logic                     fdma_busy,
  output logic                     run,
  output logic [IDX_W-1:0]         grant
);

  sched_state_e        state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         size_q, size_d;
  logic [NUM_CH-1:0]   busy_q, busy_d;
  logic [NUM_CH-1:0]   pending;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;

  assign pending = ch_areq & ~busy_q;

  // Walk from the farthest candidate back to last+1 so the nearest pending
  // channel after the previous grant is the one left in pick_idx.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    cand     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_CH);
      if (pending[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    size_d  = size_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d          = pick_idx;
          addr_d           = ch_addr[pick_idx*ADDR_W +: ADDR_W];
          size_d           = ch_size[pick_idx*32 +: 32];
          busy_d[pick_idx] = 1'b1;
          // Zero-length transfers never reach the FDMA engine.
          state_d = (ch_size[pick_idx*32 +: 32] == 32'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (fdma_busy) state_d = RUN;
      end
      RUN: begin
        if (!fdma_busy) state_d = DONE;
      end
      DONE: begin
        busy_d[grant_q] = 1'b0;
        last_d          = grant_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_CH - 1);
      addr_q  <= '0;
      size_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    ch_done = '0;
    if (state_q == DONE) ch_done[grant_q] = 1'b1;
  end

  assign ch_busy   = busy_q;
  assign fdma_areq = (state_q == ISSUE);
  assign fdma_addr = addr_q;
  assign fdma_size = size_q;
  assign run       = (state_q == RUN);
  assign grant     = grant_q;

endmodule

// File: rtl/fdma_port_arbiter.sv
// fdma_port_arbiter: shares one FDMA write port and one FDMA read port
// between NUM_CH requesters, one independent round-robin scheduler per
// direction. Data is routed only to/from the granted channel while its
// transfer is running; read data is broadcast to all channels.
// Ports:
//   m_axi_aclk, m_axi_aresetn         clock, asynchronous active-low reset
//   ch_{w,r}_areq/addr/size           per-channel requests (packed, ch i at slice i)
//   ch_{w,r}_busy, ch_{w,r}_done      per-channel status
//   ch_w_data/valid/ready             write data streams from the channels
//   ch_r_data/valid/ready             read data stream to the channels
//   fdma_{w,r}_*                      single FDMA write/read port
// Optional: FDMA_ARB_STATS_EN adds w_done_cnt/r_done_cnt, 16-bit wrapping
// per-channel completion counters (size-0 requests included).
module fdma_port_arbiter
  import fdma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
`ifdef FDMA_ARB_STATS_EN
  output logic [NUM_CH*STATS_CNT_W-1:0] w_done_cnt,
  output logic [NUM_CH*STATS_CNT_W-1:0] r_done_cnt,
`endif
  input  logic [NUM_CH-1:0]             ch_w_areq,
  input  logic [NUM_CH*ADDR_W-1:0]      ch_w_addr,
  input  logic [NUM_CH*32-1:0]          ch_w_size,
  output logic [NUM_CH-1:0]             ch_w_busy,
  output logic [NUM_CH-1:0]             ch_w_done,
  input  logic [NUM_CH*DATA_W-1:0]      ch_w_data,
  output logic [NUM_CH-1:0]             ch_w_valid,
  input  logic [NUM_CH-1:0]             ch_w_ready,
  input  logic [NUM_CH-1:0]             ch_r_areq,
  input  logic [NUM_CH*ADDR_W-1:0]      ch_r_addr,
  input  logic [NUM_CH*32-1:0]          ch_r_size,
  output logic [NUM_CH-1:0]             ch_r_busy,
  output logic [NUM_CH-1:0]             ch_r_done,
  output logic [DATA_W-1:0]             ch_r_data,
  output logic [NUM_CH-1:0]             ch_r_valid,
  input  logic [NUM_CH-1:0]             ch_r_ready,
  output logic [ADDR_W-1:0]             fdma_w_addr,
  output logic                          fdma_w_areq,
  output logic [31:0]                   fdma_w_size,
  input  logic                          fdma_w_busy,
  output logic [DATA_W-1:0]             fdma_w_data,
  input  logic                          fdma_w_valid,
  output logic                          fdma_w_ready,
  output logic [ADDR_W-1:0]             fdma_r_addr,
  output logic                          fdma_r_areq,
  output logic [31:0]                   fdma_r_size,
  input  logic                          fdma_r_busy,
  input  logic [DATA_W-1:0]             fdma_r_data,
  input  logic                          fdma_r_valid,
  output logic                          fdma_r_ready
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             w_run, r_run;
  logic [IDX_W-1:0] w_grant, r_grant;

  fdma_chan_sched #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_w_sched (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .ch_areq   (ch_w_areq),
    .ch_addr   (ch_w_addr),
    .ch_size   (ch_w_size),
    .ch_busy   (ch_w_busy),
    .ch_done   (ch_w_done),
    .fdma_areq (fdma_w_areq),
    .fdma_addr (fdma_w_addr),
    .fdma_size (fdma_w_size),
    .fdma_busy (fdma_w_busy),
    .run       (w_run),
    .grant     (w_grant)
  );

  fdma_chan_sched #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_r_sched (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .ch_areq   (ch_r_areq),
    .ch_addr   (ch_r_addr),
    .ch_size   (ch_r_size),
    .ch_busy   (ch_r_busy),
    .ch_done   (ch_r_done),
    .fdma_areq (fdma_r_areq),
    .fdma_addr (fdma_r_addr),
    .fdma_size (fdma_r_size),
    .fdma_busy (fdma_r_busy),
    .run       (r_run),
    .grant     (r_grant)
  );

  // Outside RUN every routed signal is held low so a channel never sees a
  // handshake belonging to another channel's transfer.
  always_comb begin
    fdma_w_data  = '0;
    fdma_w_ready = 1'b0;
    ch_w_valid   = '0;
    if (w_run) begin
      fdma_w_data         = ch_w_data[w_grant*DATA_W +: DATA_W];
      fdma_w_ready        = ch_w_ready[w_grant];
      ch_w_valid[w_grant] = fdma_w_valid;
    end
  end

  always_comb begin
    fdma_r_ready = 1'b0;
    ch_r_valid   = '0;
    if (r_run) begin
      fdma_r_ready        = ch_r_ready[r_grant];
      ch_r_valid[r_grant] = fdma_r_valid;
    end
  end

  assign ch_r_data = fdma_r_data;

`ifdef FDMA_ARB_STATS_EN
  logic [NUM_CH*STATS_CNT_W-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;

  always_comb begin
    w_cnt_d = w_cnt_q;
    r_cnt_d = r_cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_w_done[c])
        w_cnt_d[c*STATS_CNT_W +: STATS_CNT_W] = w_cnt_q[c*STATS_CNT_W +: STATS_CNT_W] + STATS_CNT_W'(1);
      if (ch_r_done[c])
        r_cnt_d[c*STATS_CNT_W +: STATS_CNT_W] = r_cnt_q[c*STATS_CNT_W +: STATS_CNT_W] + STATS_CNT_W'(1);
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      w_cnt_q <= '0;
      r_cnt_q <= '0;
    end else begin
      w_cnt_q <= w_cnt_d;
      r_cnt_q <= r_cnt_d;
    end
  end

  assign w_done_cnt = w_cnt_q;
  assign r_done_cnt = r_cnt_q;
`endif

endmodule

// File: tb/tb_fdma_port_arbiter.sv
`timescale 1ns/1ps
module tb_fdma_port_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]        ch_w_areq, ch_r_areq;
  logic [NUM_CH*ADDR_W-1:0] ch_w_addr, ch_r_addr;
  logic [NUM_CH*32-1:0]     ch_w_size, ch_r_size;
  logic [NUM_CH-1:0]        ch_w_busy, ch_w_done, ch_r_busy, ch_r_done;
  logic [NUM_CH*DATA_W-1:0] ch_w_data;
  logic [NUM_CH-1:0]        ch_w_valid, ch_w_ready, ch_r_valid, ch_r_ready;
  logic [DATA_W-1:0]        ch_r_data;
  logic [ADDR_W-1:0]        fdma_w_addr, fdma_r_addr;
  logic                     fdma_w_areq, fdma_r_areq;
  logic [31:0]              fdma_w_size, fdma_r_size;
  logic                     fdma_w_busy, fdma_r_busy;
  logic [DATA_W-1:0]        fdma_w_data, fdma_r_data;
  logic                     fdma_w_valid, fdma_w_ready, fdma_r_valid, fdma_r_ready;
`ifdef FDMA_ARB_STATS_EN
  logic [NUM_CH*16-1:0]     w_done_cnt, r_done_cnt;
`endif

  fdma_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
`ifdef FDMA_ARB_STATS_EN
    .w_done_cnt    (w_done_cnt),
    .r_done_cnt    (r_done_cnt),
`endif
    .ch_w_areq     (ch_w_areq),
    .ch_w_addr     (ch_w_addr),
    .ch_w_size     (ch_w_size),
    .ch_w_busy     (ch_w_busy),
    .ch_w_done     (ch_w_done),
    .ch_w_data     (ch_w_data),
    .ch_w_valid    (ch_w_valid),
    .ch_w_ready    (ch_w_ready),
    .ch_r_areq     (ch_r_areq),
    .ch_r_addr     (ch_r_addr),
    .ch_r_size     (ch_r_size),
    .ch_r_busy     (ch_r_busy),
    .ch_r_done     (ch_r_done),
    .ch_r_data     (ch_r_data),
    .ch_r_valid    (ch_r_valid),
    .ch_r_ready    (ch_r_ready),
    .fdma_w_addr   (fdma_w_addr),
    .fdma_w_areq   (fdma_w_areq),
    .fdma_w_size   (fdma_w_size),
    .fdma_w_busy   (fdma_w_busy),
    .fdma_w_data   (fdma_w_data),
    .fdma_w_valid  (fdma_w_valid),
    .fdma_w_ready  (fdma_w_ready),
    .fdma_r_addr   (fdma_r_addr),
    .fdma_r_areq   (fdma_r_areq),
    .fdma_r_size   (fdma_r_size),
    .fdma_r_busy   (fdma_r_busy),
    .fdma_r_data   (fdma_r_data),
    .fdma_r_valid  (fdma_r_valid),
    .fdma_r_ready  (fdma_r_ready)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] size; } req_t;
  typedef struct packed { logic [1:0] ch; logic [DATA_W-1:0] data; } beat_t;

  req_t  wreq_q[$], rreq_q[$];
  beat_t wdat_q[$], rdat_q[$];
  int    wdone_q[$], rdone_q[$];
  int    checks = 0;
  int    errors = 0;
  int    wbase[NUM_CH];
  logic [31:0] wcnt[NUM_CH];
  logic  rnd_mode;
  int    w_areq_cnt = 0;
  int    w_busy_cnt2 = 0;

  function automatic logic [DATA_W-1:0] wpat(input int c, input int k);
    return {32'(c), 32'hC0DE_0000, 64'(k)};
  endfunction

  function automatic logic [DATA_W-1:0] rpat(input logic [31:0] addr, input int k);
    return {96'h0, addr + 32'(k)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push_w(input int c, input logic [31:0] addr, input int n);
    if (n != 0) begin
      wreq_q.push_back('{addr, 32'(n)});
      for (int k = 0; k < n; k++) wdat_q.push_back('{2'(c), wpat(c, wbase[c] + k)});
      wbase[c] += n;
    end
    wdone_q.push_back(c);
  endfunction

  function automatic void push_r(input int c, input logic [31:0] addr, input int n);
    rreq_q.push_back('{addr, 32'(n)});
    for (int k = 0; k < n; k++) rdat_q.push_back('{2'(c), rpat(addr, k)});
    rdone_q.push_back(c);
  endfunction

  function automatic void flush_all();
    wreq_q.delete(); rreq_q.delete(); wdat_q.delete(); rdat_q.delete();
    wdone_q.delete(); rdone_q.delete();
  endfunction

  // Channel write sources: each channel presents wpat(c, beats already taken).
  always_comb begin
    ch_w_data = '0;
    for (int c = 0; c < NUM_CH; c++) ch_w_data[c*DATA_W +: DATA_W] = wpat(c, int'(wcnt[c]));
  end

  initial begin : w_source
    logic [NUM_CH-1:0] fire;
    for (int c = 0; c < NUM_CH; c++) wcnt[c] = '0;
    forever begin
      @(negedge clk);
      fire = ch_w_valid & ch_w_ready;
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!rst_n) wcnt[c] = '0;
        else if (fire[c]) wcnt[c] = wcnt[c] + 32'd1;
      end
    end
  end

  initial begin : ready_drv
    ch_w_ready = '1;
    ch_r_ready = '1;
    forever begin
      @(posedge clk); #1;
      ch_w_ready = rnd_mode ? NUM_CH'($urandom) : '1;
      ch_r_ready = rnd_mode ? NUM_CH'($urandom) : '1;
    end
  end

  // FDMA write engine model: accepts a request, raises busy, sinks size beats.
  initial begin : w_model
    logic fire, w_act;
    int   w_left;
    w_act = 1'b0; w_left = 0;
    fdma_w_busy = 1'b0; fdma_w_valid = 1'b0;
    forever begin
      @(negedge clk);
      fire = fdma_w_valid && fdma_w_ready;
      if (fire) w_left--;
      if (rst_n && !w_act && fdma_w_areq) begin
        w_act  = 1'b1;
        w_left = int'(fdma_w_size);
      end
      @(posedge clk); #1;
      if (!rst_n) begin w_act = 1'b0; w_left = 0; end
      else if (w_act && w_left == 0) w_act = 1'b0;
      fdma_w_busy  = w_act;
      fdma_w_valid = w_act && (w_left > 0) && (!rnd_mode || $urandom_range(0, 2) != 0);
    end
  end

  // FDMA read engine model: returns data = start address + beat index.
  initial begin : r_model
    logic        fire, r_act;
    int          r_left, r_beat;
    logic [31:0] r_base;
    r_act = 1'b0; r_left = 0; r_beat = 0; r_base = '0;
    fdma_r_busy = 1'b0; fdma_r_valid = 1'b0; fdma_r_data = '0;
    forever begin
      @(negedge clk);
      fire = fdma_r_valid && fdma_r_ready;
      if (fire) begin r_left--; r_beat++; end
      if (rst_n && !r_act && fdma_r_areq) begin
        r_act  = 1'b1;
        r_left = int'(fdma_r_size);
        r_base = fdma_r_addr;
        r_beat = 0;
      end
      @(posedge clk); #1;
      if (!rst_n) begin r_act = 1'b0; r_left = 0; end
      else if (r_act && r_left == 0) r_act = 1'b0;
      fdma_r_busy  = r_act;
      fdma_r_valid = r_act && (r_left > 0) && (!rnd_mode || $urandom_range(0, 2) != 0);
      fdma_r_data  = {96'h0, r_base + 32'(r_beat)};
    end
  end

  // Scoreboard monitor: pops expectations whenever the DUT presents something.
  initial begin : monitor
    req_t  rq;
    beat_t bt;
    int    dc;
    logic  w_prev, r_prev;
    w_prev = 1'b0; r_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fdma_w_areq && !w_prev) begin
          w_areq_cnt++;
          if (wreq_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_req_unexpected actual addr=%0h size=%0d required=none", fdma_w_addr, fdma_w_size);
          end else begin
            rq = wreq_q.pop_front();
            check("w_req_addr", fdma_w_addr, rq.addr);
            check("w_req_size", fdma_w_size, rq.size);
          end
        end
        if (fdma_r_areq && !r_prev) begin
          if (rreq_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_req_unexpected actual addr=%0h size=%0d required=none", fdma_r_addr, fdma_r_size);
          end else begin
            rq = rreq_q.pop_front();
            check("r_req_addr", fdma_r_addr, rq.addr);
            check("r_req_size", fdma_r_size, rq.size);
          end
        end
        if (ch_w_valid != '0) begin
          if (wdat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_valid_unexpected actual=%0h required=0", ch_w_valid);
          end else check("w_valid_route", ch_w_valid, NUM_CH'(1) << wdat_q[0].ch);
        end
        if (fdma_w_valid && fdma_w_ready) begin
          if (wdat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_beat_unexpected actual=%0h required=none", fdma_w_data);
          end else begin
            bt = wdat_q.pop_front();
            check("w_data", fdma_w_data, bt.data);
          end
        end
        if (ch_r_valid != '0) begin
          if (rdat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_valid_unexpected actual=%0h required=0", ch_r_valid);
          end else check("r_valid_route", ch_r_valid, NUM_CH'(1) << rdat_q[0].ch);
        end
        if ((ch_r_valid & ch_r_ready) != '0 && rdat_q.size() != 0) begin
          bt = rdat_q.pop_front();
          check("r_data", ch_r_data, bt.data);
        end
        if (ch_w_done != '0) begin
          if (wdone_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_done_unexpected actual=%0h required=0", ch_w_done);
          end else begin
            dc = wdone_q.pop_front();
            check("w_done", ch_w_done, NUM_CH'(1) << dc);
          end
        end
        if (ch_r_done != '0) begin
          if (rdone_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_done_unexpected actual=%0h required=0", ch_r_done);
          end else begin
            dc = rdone_q.pop_front();
            check("r_done", ch_r_done, NUM_CH'(1) << dc);
          end
        end
        if (ch_w_busy[2]) w_busy_cnt2++;
      end
      w_prev = fdma_w_areq;
      r_prev = fdma_r_areq;
    end
  end

  task automatic req_w(input int c, input logic [31:0] addr, input logic [31:0] size);
    int n;
    @(posedge clk); #1;
    ch_w_areq[c] = 1'b1;
    ch_w_addr[c*ADDR_W +: ADDR_W] = addr;
    ch_w_size[c*32 +: 32] = size;
    n = 0;
    do begin @(negedge clk); n++; end while (!ch_w_busy[c] && n < 2000);
    checks++;
    if (!ch_w_busy[c]) begin
      errors++;
      $display("FAIL w_grant_ch%0d actual=no busy after %0d cycles required=busy", c, n);
    end
    @(posedge clk); #1;
    ch_w_areq[c] = 1'b0;
  endtask

  task automatic req_r(input int c, input logic [31:0] addr, input logic [31:0] size);
    int n;
    @(posedge clk); #1;
    ch_r_areq[c] = 1'b1;
    ch_r_addr[c*ADDR_W +: ADDR_W] = addr;
    ch_r_size[c*32 +: 32] = size;
    n = 0;
    do begin @(negedge clk); n++; end while (!ch_r_busy[c] && n < 2000);
    checks++;
    if (!ch_r_busy[c]) begin
      errors++;
      $display("FAIL r_grant_ch%0d actual=no busy after %0d cycles required=busy", c, n);
    end
    @(posedge clk); #1;
    ch_r_areq[c] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((wreq_q.size() + rreq_q.size() + wdat_q.size() + rdat_q.size() +
            wdone_q.size() + rdone_q.size() != 0 || ch_w_busy != '0 || ch_r_busy != '0)
           && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_drain actual=pending wq=%0d rq=%0d required=empty", tag, wdat_q.size(), rdat_q.size());
      flush_all();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ch_w_busy"},  ch_w_busy,  '0);
    check({tag, "_ch_w_done"},  ch_w_done,  '0);
    check({tag, "_ch_w_valid"}, ch_w_valid, '0);
    check({tag, "_fdma_w_areq"}, fdma_w_areq, '0);
    check({tag, "_fdma_w_addr"}, fdma_w_addr, '0);
    check({tag, "_fdma_w_size"}, fdma_w_size, '0);
    check({tag, "_fdma_w_data"}, fdma_w_data, '0);
    check({tag, "_fdma_w_ready"}, fdma_w_ready, '0);
    check({tag, "_ch_r_busy"},  ch_r_busy,  '0);
    check({tag, "_ch_r_done"},  ch_r_done,  '0);
    check({tag, "_ch_r_valid"}, ch_r_valid, '0);
    check({tag, "_fdma_r_areq"}, fdma_r_areq, '0);
    check({tag, "_fdma_r_addr"}, fdma_r_addr, '0);
    check({tag, "_fdma_r_size"}, fdma_r_size, '0);
    check({tag, "_fdma_r_ready"}, fdma_r_ready, '0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ac;
    ch_w_areq = '0; ch_w_addr = '0; ch_w_size = '0;
    ch_r_areq = '0; ch_r_addr = '0; ch_r_size = '0;
    rnd_mode = 1'b0;
    for (int c = 0; c < NUM_CH; c++) wbase[c] = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write on channel 1.
    push_w(1, 32'h1000, 64);
    req_w(1, 32'h1000, 32'd64);
    wait_idle("t1");
    check("t1_busy_after", ch_w_busy[1], 1'b0);

    // All four read channels at once: grants must rotate 0,1,2,3.
    for (int c = 0; c < NUM_CH; c++) push_r(c, 32'h2000 + 32'(c * 32'h100), 3 + c);
    fork
      req_r(0, 32'h2000, 32'd3);
      req_r(1, 32'h2100, 32'd4);
      req_r(2, 32'h2200, 32'd5);
      req_r(3, 32'h2300, 32'd6);
    join
    wait_idle("t2");

    // Zero-length write on channel 2.
    ac = w_areq_cnt;
    w_busy_cnt2 = 0;
    push_w(2, 32'h5000, 0);
    req_w(2, 32'h5000, 32'd0);
    wait_idle("t3");
    check("t3_busy_cycles", w_busy_cnt2, 1);
    check("t3_no_fdma_areq", w_areq_cnt - ac, 0);

    // Concurrent write ch0 and read ch3 with random backpressure.
    rnd_mode = 1'b1;
    push_w(0, 32'h3000, 16);
    push_r(3, 32'h4000, 12);
    fork
      req_w(0, 32'h3000, 32'd16);
      req_r(3, 32'h4000, 32'd12);
    join
    wait_idle("t4");
    rnd_mode = 1'b0;

`ifdef FDMA_ARB_STATS_EN
    check("stats_w_cnt", w_done_cnt, {16'd0, 16'd1, 16'd1, 16'd1});
    check("stats_r_cnt", r_done_cnt, {16'd2, 16'd1, 16'd1, 16'd1});
`endif

    // Reset in the middle of a running write.
    push_w(0, 32'h6000, 40);
    req_w(0, 32'h6000, 32'd40);
    repeat (8) @(negedge clk);
    check("t5_in_run", fdma_w_busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush_all();
    for (int c = 0; c < NUM_CH; c++) wbase[c] = 0;
    @(negedge clk);
    check_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // After reset channel 0 must win over channel 3.
    push_w(0, 32'h7000, 4);
    push_w(3, 32'h7100, 4);
    fork
      req_w(3, 32'h7100, 32'd4);
      req_w(0, 32'h7000, 32'd4);
    join
    wait_idle("t6");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
